// File: rtl/mux_serializer.sv
// rtl/mux_serializer.sv - WIDTH:1 mux parallel-to-serial converter with valid/ready on both sides
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   load_valid  parallel word offered
//   load_ready  serializer can accept a word (IDLE)
//   data_in     parallel word, captured on load handshake
//   msb_first   bit order, captured on load handshake (1 = MSB first)
//   ser_out     current serial bit (0 when ser_valid=0)
//   ser_valid   ser_out holds a valid bit
//   ser_ready   downstream accepts the bit this cycle
//   ser_last    current bit is the final bit of the word
//   busy        word in flight (same as ser_valid)

module mux_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             msb_first,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] TOP = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] shadow;
  logic            order;
  logic [CW-1:0]   idx;
  logic [CW-1:0]   beat;
  logic            load_hs;
  logic            ser_hs;

  // Outputs depend only on registered state; data_in never reaches ser_out
  // combinationally.
  always_comb begin
    state_next = state;
    load_ready = 1'b0;
    ser_valid  = 1'b0;
    ser_out    = 1'b0;
    ser_last   = 1'b0;
    load_hs    = 1'b0;
    ser_hs     = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          load_hs    = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = shadow[idx];
        ser_last  = (beat == TOP);
        if (ser_ready) begin
          ser_hs = 1'b1;
          if (ser_last) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    busy = ser_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shadow <= '0;
      order  <= 1'b0;
      idx    <= '0;
      beat   <= '0;
    end else begin
      state <= state_next;
      if (load_hs) begin
        shadow <= data_in;
        order  <= msb_first;
        idx    <= msb_first ? TOP : '0;
        beat   <= '0;
      end else if (ser_hs && !ser_last) begin
        // Counters freeze on the final beat so idx never leaves 0..WIDTH-1.
        beat <= beat + CW'(1);
        idx  <= order ? (idx - CW'(1)) : (idx + CW'(1));
      end
    end
  end

endmodule

// File: tb/tb_mux_serializer.sv
// tb/tb_mux_serializer.sv - scoreboard bench for mux_serializer (WIDTH=8)

module tb_mux_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] data_in;
  logic       msb_first;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_ready;
  logic       ser_last;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;

  // Each entry: {expected bit, expected last flag}
  logic [1:0] exp_q[$];

  mux_serializer #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .data_in    (data_in),
    .msb_first  (msb_first),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .ser_last   (ser_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // stream[i] is the i-th bit expected on the wire (hand-computed).
  task automatic push_stream(input logic [7:0] stream);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({stream[i], (i == 7) ? 1'b1 : 1'b0});
    end
  endtask

  // Inputs change at posedge+1 so the negedge monitor sees stable values.
  task automatic load_word(input logic [7:0] d, input logic msb, input logic [7:0] stream);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!load_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!load_ready) check("load_ready_timeout", 8'(load_ready), 8'd1);
    load_valid = 1'b1;
    data_in    = d;
    msb_first  = msb;
    push_stream(stream);
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!load_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!load_ready) check("idle_timeout", 8'(load_ready), 8'd1);
  endtask

  // Monitor: pops one expected entry per serial handshake.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_eq_valid", 8'(busy), 8'(ser_valid));
      if (!ser_valid) begin
        check("idle_ser_out", 8'(ser_out), 8'd0);
        check("idle_ser_last", 8'(ser_last), 8'd0);
      end else if (ser_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 8'({ser_out, ser_last}), 8'hEE);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          check("ser_out", 8'(ser_out), 8'(e[1]));
          check("ser_last", 8'(ser_last), 8'(e[0]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    data_in    = 8'h00;
    msb_first  = 1'b0;
    ser_ready  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_load_ready", 8'(load_ready), 8'd1);
    check("rst_ser_valid", 8'(ser_valid), 8'd0);
    check("rst_ser_out", 8'(ser_out), 8'd0);
    check("rst_ser_last", 8'(ser_last), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);

    // LSB-first B4, no stall: bits 0,0,1,0,1,1,0,1; latency checks
    load_word(8'hB4, 1'b0, 8'hB4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("lsb_valid", 8'(ser_valid), 8'd1);
      check("lsb_last_pos", 8'(ser_last), (k == 8) ? 8'd1 : 8'd0);
      check("lsb_load_ready_busy", 8'(load_ready), 8'd0);
    end
    @(negedge clk);
    check("lsb_ready_t9", 8'(load_ready), 8'd1);
    check("lsb_valid_t9", 8'(ser_valid), 8'd0);

    // MSB-first B4: bits 1,0,1,1,0,1,0,0
    load_word(8'hB4, 1'b1, 8'h2D);
    @(posedge clk); #1;
    wait_idle();

    // Backpressure A5 LSB-first: stall 3 cycles while bit 2 (=1) is shown
    load_word(8'hA5, 1'b0, 8'hA5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ser_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("stall_hold_out", 8'(ser_out), 8'd1);
      check("stall_hold_valid", 8'(ser_valid), 8'd1);
      check("stall_hold_last", 8'(ser_last), 8'd0);
      @(posedge clk); #1;
    end
    ser_ready = 1'b1;
    wait_idle();

    // Load ignored while busy: 0F streams intact, FF taken only once idle
    load_word(8'h0F, 1'b0, 8'h0F);
    @(posedge clk); #1;
    load_valid = 1'b1;
    data_in    = 8'hFF;
    msb_first  = 1'b1;
    begin
      int n;
      n = 0;
      while (!load_ready && n < 50) begin
        @(negedge clk);
        if (!load_ready) check("held_load_busy", 8'(ser_valid), 8'd1);
        @(posedge clk); #1;
        n++;
      end
      if (!load_ready) check("held_load_timeout", 8'(load_ready), 8'd1);
    end
    push_stream(8'hFF);
    @(posedge clk); #1;
    load_valid = 1'b0;
    wait_idle();

    // Reset mid-word after 3rd bit accepted
    load_word(8'hFF, 1'b0, 8'hFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_ser_valid", 8'(ser_valid), 8'd0);
    check("midrst_load_ready", 8'(load_ready), 8'd1);
    check("midrst_ser_out", 8'(ser_out), 8'd0);

    load_word(8'h01, 1'b0, 8'h01);
    @(posedge clk); #1;
    wait_idle();
    repeat (2) @(posedge clk);

    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
